fifo_byte_tx: RTL and testbench

FIFO_BYTE_TX -- requirements
Module: fifo_byte_tx

---
 rtl/fifo_tx_pkg.sv | 21 ++
 rtl/fifo_tx_baud_gen.sv | 34 +++
 rtl/fifo_byte_tx.sv | 136 +++++++++++++
 tb/tb_fifo_byte_tx.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_tx_pkg.sv
// Purpose : shared types and widths for the FIFO-draining byte transmitter.
// Latency : n/a (package only).
// Backpressure: n/a (package only).
// Contents: tx_state_t frame sequencer states, data / bit-index / baud-counter widths.
package fifo_tx_pkg;

   localparam int DATA_W = 8;    // bits per serial character
   localparam int IDX_W  = 3;    // bit index within a character, counts 0..7
   localparam int BAUD_W = 16;   // bit-period counter, covers CLKS_PER_BIT up to 65535

   typedef enum logic [2:0] {
      IDLE,
      POP,
      LOAD,
      START,
      DATA,
      PARITY,
      STOP
   } tx_state_t;

endpackage

// File: rtl/fifo_tx_baud_gen.sv
// Purpose : bit-period counter; ticks on the last clock of every serial bit period.
// Latency : tick is a decode of the counter register, restart takes effect on the next edge.
// Backpressure: none; free-running between restarts.
// Ports   : clk, rst (sync, active-high), restart (zero the counter at the next edge),
//           tick (high on the final clock of the current bit period).
module fifo_tx_baud_gen
   import fifo_tx_pkg::*;
#(
   parameter int CLKS_PER_BIT = 16
)
(
   input  logic clk,
   input  logic rst,
   input  logic restart,
   output logic tick
);

   localparam logic [BAUD_W-1:0] CNT_MAX = BAUD_W'(CLKS_PER_BIT - 1);

   logic [BAUD_W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst || restart) begin
         cnt <= '0;
      end else if (cnt == CNT_MAX) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + BAUD_W'(1);
      end
   end

   assign tick = (cnt == CNT_MAX);

endmodule

// File: rtl/fifo_byte_tx.sv
// Purpose : pops bytes from a FIFO and sends each as an async serial frame (start, 8 data LSB first, opt. even parity, stop).
// Latency : fifo_rd cycle -> first start-bit cycle is 3 clocks (POP, LOAD, then START).
// Backpressure: pops only when enable=1 and fifo_empty=0; checked in IDLE and on the last stop clock.
// Ports   : clk, rst (sync, active-high), enable, fifo_empty, fifo_data[7:0] (valid the cycle after fifo_rd)
//           -> fifo_rd (one-cycle pop), tx (serial line, idle high), busy, frame_done (last stop clock).
module fifo_byte_tx
   import fifo_tx_pkg::*;
#(
   parameter int CLKS_PER_BIT = 16,
   parameter int STOP_BITS    = 1,
   parameter int PARITY_EN    = 0
)
(
   input  logic              clk,
   input  logic              rst,
   input  logic              enable,
   input  logic              fifo_empty,
   input  logic [DATA_W-1:0] fifo_data,
   output logic              fifo_rd,
   output logic              tx,
   output logic              busy,
   output logic              frame_done
);

   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_W - 1);
   localparam logic             STOP_LAST = 1'(STOP_BITS - 1);

   tx_state_t         state;
   tx_state_t         state_nxt;
   logic [DATA_W-1:0] shreg;
   logic              parity_bit;
   logic [IDX_W-1:0]  bit_idx;
   logic              stop_cnt;
   logic              tick;
   logic              restart;
   logic              can_pop;

   assign can_pop = enable && !fifo_empty;

   // Any state change restarts the bit period, so every state starts counting from zero.
   assign restart = (state_nxt != state);

   fifo_tx_baud_gen #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_baud (
      .clk     (clk),
      .rst     (rst),
      .restart (restart),
      .tick    (tick)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         shreg      <= '0;
         parity_bit <= 1'b0;
         bit_idx    <= '0;
         stop_cnt   <= 1'b0;
      end else begin
         state <= state_nxt;
         case (state)
            LOAD: begin
               shreg      <= fifo_data;
               parity_bit <= ^fifo_data;
            end
            START:   bit_idx <= '0;
            DATA:    if (tick) bit_idx <= bit_idx + IDX_W'(1);
            default: ;
         endcase
         if (state != STOP) begin
            stop_cnt <= 1'b0;
         end else if (tick) begin
            stop_cnt <= stop_cnt + 1'b1;
         end
      end
   end

   always_comb begin
      state_nxt  = state;
      fifo_rd    = 1'b0;
      frame_done = 1'b0;
      case (state)
         IDLE: begin
            if (can_pop) begin
               fifo_rd   = 1'b1;
               state_nxt = POP;
            end
         end
         POP:  state_nxt = LOAD;   // FIFO read latency
         LOAD: state_nxt = START;
         START: begin
            if (tick) state_nxt = DATA;
         end
         DATA: begin
            if (tick && (bit_idx == IDX_LAST)) begin
               state_nxt = (PARITY_EN != 0) ? PARITY : STOP;
            end
         end
         PARITY: begin
            if (tick) state_nxt = STOP;
         end
         STOP: begin
            if (tick && (stop_cnt == STOP_LAST)) begin
               frame_done = 1'b1;
               // Chain straight into the next byte without passing through IDLE.
               if (can_pop) begin
                  fifo_rd   = 1'b1;
                  state_nxt = POP;
               end else begin
                  state_nxt = IDLE;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
      // Strobes are decoded from state, so mask them while reset is held.
      if (rst) begin
         state_nxt  = IDLE;
         fifo_rd    = 1'b0;
         frame_done = 1'b0;
      end
   end

   always_comb begin
      tx = 1'b1;
      case (state)
         START:   tx = 1'b0;
         DATA:    tx = shreg[bit_idx];
         PARITY:  tx = parity_bit;
         default: tx = 1'b1;
      endcase
   end

   assign busy = (state != IDLE);

endmodule

// File: tb/tb_fifo_byte_tx.sv
// Purpose : directed self-checking bench for fifo_byte_tx (default config and parity/2-stop config).
// Latency : n/a.
// Backpressure: n/a.
module tb_fifo_byte_tx;

   localparam int LOGN  = 1024;
   localparam int S_TXA = 0;
   localparam int S_RDA = 1;
   localparam int S_FDA = 2;
   localparam int S_BSA = 3;
   localparam int S_TXB = 4;
   localparam int S_RDB = 5;
   localparam int S_FDB = 6;
   localparam int S_BSB = 7;

   logic       clk        = 1'b0;
   logic       rst        = 1'b1;
   logic       enable     = 1'b0;
   logic       enable_b   = 1'b0;
   logic       fifo_empty = 1'b1;
   logic [7:0] fifo_data  = 8'h00;
   logic       fifo_rd, tx, busy, frame_done;
   logic       fifo_empty_b;
   logic [7:0] fifo_data_b;
   logic       fifo_rd_b, tx_b, busy_b, frame_done_b;

   logic [7:0] fq[$];
   int         b_pending  = 0;
   int         b_pops     = 0;
   int         underflows = 0;
   int         n_checks   = 0;
   int         n_errors   = 0;
   int         nlog       = 0;
   bit         lg [0:7][0:LOGN-1];

   always #5 clk = ~clk;

   fifo_byte_tx dut_a (
      .clk        (clk),
      .rst        (rst),
      .enable     (enable),
      .fifo_empty (fifo_empty),
      .fifo_data  (fifo_data),
      .fifo_rd    (fifo_rd),
      .tx         (tx),
      .busy       (busy),
      .frame_done (frame_done)
   );

   fifo_byte_tx #(
      .CLKS_PER_BIT (16),
      .STOP_BITS    (2),
      .PARITY_EN    (1)
   ) dut_b (
      .clk        (clk),
      .rst        (rst),
      .enable     (enable_b),
      .fifo_empty (fifo_empty_b),
      .fifo_data  (fifo_data_b),
      .fifo_rd    (fifo_rd_b),
      .tx         (tx_b),
      .busy       (busy_b),
      .frame_done (frame_done_b)
   );

   // Second transmitter is fed an endless supply of 0x07, gated by a pending-byte count.
   assign fifo_data_b  = 8'h07;
   assign fifo_empty_b = (b_pops >= b_pending);

   // Byte FIFO model: data valid the cycle after fifo_rd; empty flag registered.
   always @(posedge clk) begin
      if (fifo_rd) begin
         if (fq.size() > 0) begin
            fifo_data <= fq[0];
            void'(fq.pop_front());
         end else begin
            underflows <= underflows + 1;
         end
      end
      fifo_empty <= (fq.size() == 0);
      if (fifo_rd_b) b_pops <= b_pops + 1;
   end

   task automatic chk(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   // Samples 1 time unit after each falling edge, starting in the current half cycle.
   task automatic capture(input int n);
      for (int i = 0; i < n; i++) begin
         #1;
         if (nlog < LOGN) begin
            lg[S_TXA][nlog] = tx;
            lg[S_RDA][nlog] = fifo_rd;
            lg[S_FDA][nlog] = frame_done;
            lg[S_BSA][nlog] = busy;
            lg[S_TXB][nlog] = tx_b;
            lg[S_RDB][nlog] = fifo_rd_b;
            lg[S_FDB][nlog] = frame_done_b;
            lg[S_BSB][nlog] = busy_b;
         end
         nlog++;
         @(negedge clk);
      end
   endtask

   function automatic int at(input int sel, input int idx);
      if (idx < 0 || idx >= nlog || idx >= LOGN) return -1;
      return int'(lg[sel][idx]);
   endfunction

   function automatic int first(input int sel, input int val, input int from);
      if (from < 0) return -1;
      for (int i = from; i < nlog && i < LOGN; i++) begin
         if (int'(lg[sel][i]) == val) return i;
      end
      return -1;
   endfunction

   function automatic int count(input int sel, input int val, input int from, input int to);
      int c = 0;
      for (int i = from; i <= to; i++) begin
         if (at(sel, i) == val) c++;
      end
      return c;
   endfunction

   // Expected line level k clocks after a start bit begins, 16 clocks per bit.
   function automatic int exp_tx(input logic [7:0] d, input int k, input int par_en);
      if (k < 16)                  return 0;
      if (k < 144)                 return int'((d >> ((k - 16) / 16)) & 8'h01);
      if (par_en != 0 && k < 160)  return int'(^d);
      return 1;
   endfunction

   function automatic int seg_err(input int sel, input int start, input int n, input int v);
      int e = 0;
      if (start < 0) return n;
      for (int k = 0; k < n; k++) begin
         if (at(sel, start + k) != v) e++;
      end
      return e;
   endfunction

   function automatic int frame_err(input int sel, input int s, input logic [7:0] d,
                                    input int par_en, input int len);
      int e = 0;
      if (s < 0) return len;
      for (int k = 0; k < len; k++) begin
         if (at(sel, s + k) != exp_tx(d, k, par_en)) e++;
      end
      return e;
   endfunction

   initial begin
      int r, s, f, f1, f2, f3, s1, s2, s3;

      // Reset state
      repeat (3) @(negedge clk);
      #1;
      chk("rst_tx", int'(tx), 1);
      chk("rst_busy", int'(busy), 0);
      chk("rst_fifo_rd", int'(fifo_rd), 0);
      chk("rst_frame_done", int'(frame_done), 0);
      chk("rst_tx_b", int'(tx_b), 1);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // Single byte 0xA5, default configuration
      fq.push_back(8'hA5);
      @(negedge clk);
      enable = 1'b1;
      nlog = 0;
      capture(200);
      r = first(S_RDA, 1, 0);
      s = first(S_TXA, 0, 0);
      f = first(S_FDA, 1, 0);
      chk("a5_rd_index", r, 0);
      chk("a5_rd_to_start", s - r, 3);
      chk("a5_rd_count", count(S_RDA, 1, 0, nlog - 1), 1);
      chk("a5_tx_load", at(S_TXA, s - 1), 1);
      for (int b = 0; b < 10; b++) begin
         chk($sformatf("a5_bit%0d_bad_clocks", b),
             seg_err(S_TXA, s + 16 * b, 16, exp_tx(8'hA5, 16 * b, 0)), 0);
      end
      // Start bit is clock 1, so the 160th clock is offset 159.
      chk("a5_frame_done_pos", f - s, 159);
      chk("a5_frame_done_count", count(S_FDA, 1, 0, nlog - 1), 1);
      chk("a5_busy_at_rd", at(S_BSA, r), 0);
      chk("a5_busy_at_pop", at(S_BSA, r + 1), 1);
      chk("a5_busy_after", at(S_BSA, f + 1), 0);

      // Empty FIFO with enable held high
      nlog = 0;
      capture(500);
      chk("empty_rd_count", count(S_RDA, 1, 0, nlog - 1), 0);
      chk("empty_busy_count", count(S_BSA, 1, 0, nlog - 1), 0);
      chk("empty_fd_count", count(S_FDA, 1, 0, nlog - 1), 0);
      chk("empty_tx_low_count", count(S_TXA, 0, 0, nlog - 1), 0);

      // Parity + two stop bits, byte 0x07
      b_pending = 1;
      enable_b  = 1'b1;
      nlog = 0;
      capture(230);
      enable_b = 1'b0;
      r = first(S_RDB, 1, 0);
      s = first(S_TXB, 0, 0);
      f = first(S_FDB, 1, 0);
      chk("par_rd_to_start", s - r, 3);
      chk("par_rd_count", count(S_RDB, 1, 0, nlog - 1), 1);
      chk("par_frame_bad_clocks", frame_err(S_TXB, s, 8'h07, 1, 192), 0);
      chk("par_parity_bit", at(S_TXB, s + 152), 1);
      chk("par_second_stop", at(S_TXB, s + 184), 1);
      chk("par_frame_done_pos", f - s, 191);
      chk("par_busy_after", at(S_BSB, f + 1), 0);

      // Back-to-back 0x01, 0x80, 0xFF
      fq.push_back(8'h01);
      fq.push_back(8'h80);
      fq.push_back(8'hFF);
      @(negedge clk);
      nlog = 0;
      capture(520);
      f1 = first(S_FDA, 1, 0);
      f2 = first(S_FDA, 1, f1 + 1);
      f3 = first(S_FDA, 1, f2 + 1);
      s1 = first(S_TXA, 0, 0);
      s2 = first(S_TXA, 0, f1 + 1);
      s3 = first(S_TXA, 0, f2 + 1);
      chk("b2b_rd_count", count(S_RDA, 1, 0, nlog - 1), 3);
      chk("b2b_fd_count", count(S_FDA, 1, 0, nlog - 1), 3);
      // frame_done clock, POP, LOAD, then start bit on the fourth clock
      chk("b2b_gap1", s2 - f1, 3);
      chk("b2b_gap2", s3 - f2, 3);
      chk("b2b_frame1_bad", frame_err(S_TXA, s1, 8'h01, 0, 160), 0);
      chk("b2b_frame2_bad", frame_err(S_TXA, s2, 8'h80, 0, 160), 0);
      chk("b2b_frame3_bad", frame_err(S_TXA, s3, 8'hFF, 0, 160), 0);
      chk("b2b_busy_gaps", count(S_BSA, 0, 1, f3), 0);
      chk("b2b_busy_after", at(S_BSA, f3 + 1), 0);

      // Reset at DATA clock 40 of 0x5A, 0x33 queued behind it
      fq.push_back(8'h5A);
      fq.push_back(8'h33);
      @(negedge clk);
      nlog = 0;
      capture(58);
      rst = 1'b1;
      capture(3);
      rst = 1'b0;
      capture(200);
      chk("rstmid_busy_before", at(S_BSA, 57), 1);
      chk("rstmid_tx", at(S_TXA, 59), 1);
      chk("rstmid_busy", at(S_BSA, 59), 0);
      chk("rstmid_no_fd", count(S_FDA, 1, 0, 60), 0);
      chk("rstmid_no_rd_in_rst", count(S_RDA, 1, 58, 60), 0);
      chk("rstmid_repop", at(S_RDA, 61), 1);
      s = first(S_TXA, 0, 62);
      chk("rstmid_restart", s, 64);
      chk("rstmid_frame_bad", frame_err(S_TXA, s, 8'h33, 0, 160), 0);
      chk("rstmid_rd_count", count(S_RDA, 1, 0, nlog - 1), 2);
      chk("rstmid_fd_count", count(S_FDA, 1, 0, nlog - 1), 1);

      // enable dropped during the start bit of 0x3C
      fq.push_back(8'h3C);
      fq.push_back(8'h11);
      @(negedge clk);
      nlog = 0;
      capture(5);
      enable = 1'b0;
      capture(300);
      chk("endrop_rd_count", count(S_RDA, 1, 0, nlog - 1), 1);
      chk("endrop_frame_bad", frame_err(S_TXA, 3, 8'h3C, 0, 160), 0);
      chk("endrop_fd_pos", first(S_FDA, 1, 0), 162);
      chk("endrop_busy_after", at(S_BSA, 163), 0);
      chk("endrop_fifo_left", fq.size(), 1);

      chk("fifo_underflows", underflows, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
